// File: rtl/data_ctrl_pkg.sv
// Shared definitions for the data-memory sequencer: op codes, FSM encoding, width defaults.
package data_ctrl_pkg;
  localparam int ADDR_W_DFLT = 8;
  localparam int DATA_W_DFLT = 16;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_FILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_CP_RD, S_CP_WR, S_FILL, S_DONE
  } state_e;
endpackage

// File: rtl/data_ctrl.sv
// Load/store/copy/fill sequencer; sole master of the 256x16 data memory.
module data_ctrl
  import data_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_addr2,
  input  logic [7:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d, rsp_data_q, rsp_data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // data_q doubles as the STORE/FILL value and the COPY word buffer.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          src_d  = cmd_addr;
          dst_d  = (op_e'(cmd_op) == OP_FILL) ? cmd_addr : cmd_addr2;
          cnt_d  = cmd_len;
          data_d = cmd_data;
          unique case (op_e'(cmd_op))
            OP_LOAD:  state_d = S_LOAD;
            OP_STORE: state_d = S_STORE;
            OP_COPY:  state_d = (cmd_len == 8'd0) ? S_DONE : S_CP_RD;
            OP_FILL:  state_d = (cmd_len == 8'd0) ? S_DONE : S_FILL;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        rsp_data_d = mem_dout;
        state_d    = S_DONE;
      end
      S_STORE: state_d = S_DONE;
      S_CP_RD: begin
        data_d  = mem_dout;
        src_d   = src_q + ADDR_W'(1);
        state_d = S_CP_WR;
      end
      S_CP_WR: begin
        dst_d   = dst_q + ADDR_W'(1);
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? S_DONE : S_CP_RD;
      end
      S_FILL: begin
        dst_d   = dst_q + ADDR_W'(1);
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? S_DONE : S_FILL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port decodes from registered state only.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    unique case (state_q)
      S_LOAD:  mem_addr = src_q;
      S_STORE: begin mem_addr = src_q; mem_din = data_q; mem_we = 1'b1; end
      S_CP_RD: mem_addr = src_q;
      S_CP_WR: begin mem_addr = dst_q; mem_din = data_q; mem_we = 1'b1; end
      S_FILL:  begin mem_addr = dst_q; mem_din = data_q; mem_we = 1'b1; end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_data_ctrl.sv
// Directed bench for data_ctrl with a behavioural 256x16 memory attached.
module tb_data_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr, cmd_addr2, cmd_len;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout;

  logic [15:0] mem [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  data_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_addr2(cmd_addr2), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  // Issues one command from IDLE; reports the cycle of rsp_valid (1 = cycle after accept) and write count.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] a2,
                         input logic [7:0] len, input logic [15:0] d,
                         output int rsp_cyc, output int we_cnt);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_addr2 = a2; cmd_len = len; cmd_data = d;
    @(posedge clk);
    rsp_cyc = -1; we_cnt = 0;
    for (int c = 1; c <= 600 && rsp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      if (mem_we) we_cnt++;
      if (rsp_valid) rsp_cyc = c;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 8'h05;
    cmd_addr2 = 8'h00; cmd_len = 8'd3; cmd_data = 16'h1234;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); @(negedge clk);
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
      total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b/%b exp=1/0", cmd_ready, busy); end
      total++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0) begin bad++; $display("FAIL reset_rsp got=%b/%h exp=0/0000", rsp_valid, rsp_data); end
      total++; if (mem_addr !== 8'h0 || mem_din !== 16'h0) begin bad++; $display("FAIL reset_mem got=%h/%h exp=00/0000", mem_addr, mem_din); end
    end
    cmd_valid = 1'b0; rst_n = 1'b1;
    total++; if (mem[8'h05] !== 16'h1005) begin bad++; $display("FAIL reset_nowrite got=%h exp=1005", mem[8'h05]); end
  endtask

  task automatic test_store_load;
    int rc, wc;
    run_cmd(2'b01, 8'h10, 8'h00, 8'd0, 16'hBEEF, rc, wc);
    total++; if (rc !== 2) begin bad++; $display("FAIL store_rsp got=%0d exp=2", rc); end
    total++; if (wc !== 1) begin bad++; $display("FAIL store_we got=%0d exp=1", wc); end
    total++; if (mem[8'h10] !== 16'hBEEF) begin bad++; $display("FAIL store_mem got=%h exp=beef", mem[8'h10]); end
    run_cmd(2'b00, 8'h10, 8'h00, 8'd0, 16'h0000, rc, wc);
    total++; if (rc !== 2) begin bad++; $display("FAIL load_rsp got=%0d exp=2", rc); end
    total++; if (rsp_data !== 16'hBEEF) begin bad++; $display("FAIL load_data got=%h exp=beef", rsp_data); end
    total++; if (wc !== 0) begin bad++; $display("FAIL load_we got=%0d exp=0", wc); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || rsp_data !== 16'hBEEF) begin bad++; $display("FAIL load_hold got=%b/%h exp=0/beef", rsp_valid, rsp_data); end
  endtask

  task automatic test_copy_wrap;
    int rc, wc;
    run_cmd(2'b10, 8'hFE, 8'h20, 8'd4, 16'h0000, rc, wc);
    total++; if (rc !== 9) begin bad++; $display("FAIL copy_rsp got=%0d exp=9", rc); end
    total++; if (wc !== 4) begin bad++; $display("FAIL copy_we got=%0d exp=4", wc); end
    total++; if (mem[8'h20] !== 16'h10FE || mem[8'h21] !== 16'h10FF)
      begin bad++; $display("FAIL copy_lo got=%h,%h exp=10fe,10ff", mem[8'h20], mem[8'h21]); end
    total++; if (mem[8'h22] !== 16'h1000 || mem[8'h23] !== 16'h1001)
      begin bad++; $display("FAIL copy_wrap got=%h,%h exp=1000,1001", mem[8'h22], mem[8'h23]); end
    total++; if (mem[8'h24] !== 16'h1024) begin bad++; $display("FAIL copy_edge got=%h exp=1024", mem[8'h24]); end
  endtask

  task automatic test_copy_overlap;
    int rc, wc;
    run_cmd(2'b01, 8'h40, 8'h00, 8'd0, 16'h1111, rc, wc);
    run_cmd(2'b10, 8'h40, 8'h41, 8'd3, 16'h0000, rc, wc);
    total++; if (rc !== 7) begin bad++; $display("FAIL ovl_rsp got=%0d exp=7", rc); end
    total++; if (mem[8'h41] !== 16'h1111 || mem[8'h42] !== 16'h1111 || mem[8'h43] !== 16'h1111)
      begin bad++; $display("FAIL ovl_data got=%h,%h,%h exp=1111 x3", mem[8'h41], mem[8'h42], mem[8'h43]); end
    total++; if (mem[8'h44] !== 16'h1044) begin bad++; $display("FAIL ovl_edge got=%h exp=1044", mem[8'h44]); end
  endtask

  task automatic test_zero_len;
    int rc, wc;
    run_cmd(2'b10, 8'h00, 8'h50, 8'd0, 16'h0000, rc, wc);
    total++; if (rc !== 1 || wc !== 0) begin bad++; $display("FAIL zcopy got=rsp%0d/we%0d exp=rsp1/we0", rc, wc); end
    run_cmd(2'b11, 8'h50, 8'h00, 8'd0, 16'hFFFF, rc, wc);
    total++; if (rc !== 1 || wc !== 0) begin bad++; $display("FAIL zfill got=rsp%0d/we%0d exp=rsp1/we0", rc, wc); end
    total++; if (mem[8'h50] !== 16'h1050) begin bad++; $display("FAIL zmem got=%h exp=1050", mem[8'h50]); end
  endtask

  task automatic test_back_to_back;
    int we = 0, rdy = 0, rc = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 8'h20; cmd_addr2 = 8'h60; cmd_len = 8'd2; cmd_data = 16'h0;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (mem_we) we++;
      if (cmd_ready) rdy++;
      if (rsp_valid) rc = c;
      cmd_op = 2'b01; cmd_addr = 8'h70; cmd_addr2 = 8'(c); cmd_len = 8'(c); cmd_data = 16'h5000 + 16'(c);
    end
    total++; if (we !== 2 || rdy !== 0 || rc !== 5)
      begin bad++; $display("FAIL bp_copy got=we%0d/rdy%0d/rsp%0d exp=we2/rdy0/rsp5", we, rdy, rc); end
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready got=%b exp=1", cmd_ready); end
    cmd_data = 16'h6666;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    total++; if (mem_we !== 1'b1 || mem_addr !== 8'h70 || mem_din !== 16'h6666)
      begin bad++; $display("FAIL bp_store got=%b/%h/%h exp=1/70/6666", mem_we, mem_addr, mem_din); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp got=%b exp=1", rsp_valid); end
    total++; if (mem[8'h60] !== 16'h10FE || mem[8'h61] !== 16'h10FF || mem[8'h70] !== 16'h6666)
      begin bad++; $display("FAIL bp_mem got=%h,%h,%h exp=10fe,10ff,6666", mem[8'h60], mem[8'h61], mem[8'h70]); end
  endtask

  task automatic test_fill;
    int rc, wc;
    run_cmd(2'b11, 8'h80, 8'h00, 8'd255, 16'hA5A5, rc, wc);
    total++; if (rc !== 256 || wc !== 255) begin bad++; $display("FAIL fill_cnt got=rsp%0d/we%0d exp=rsp256/we255", rc, wc); end
    total++; if (mem[8'h80] !== 16'hA5A5 || mem[8'hFF] !== 16'hA5A5 || mem[8'h00] !== 16'hA5A5 || mem[8'h7E] !== 16'hA5A5)
      begin bad++; $display("FAIL fill_data got=%h,%h,%h,%h exp=a5a5", mem[8'h80], mem[8'hFF], mem[8'h00], mem[8'h7E]); end
    total++; if (mem[8'h7F] !== 16'h107F) begin bad++; $display("FAIL fill_edge got=%h exp=107f", mem[8'h7F]); end
  endtask

  task automatic test_reset_mid_fill;
    int n = 0, post = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 8'h30; cmd_len = 8'd10; cmd_data = 16'h7777;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (mem_we !== 1'b0 || cmd_ready !== 1'b1)
      begin bad++; $display("FAIL mrst_state got=we%b/rdy%b exp=we0/rdy1", mem_we, cmd_ready); end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid || mem_we) post++;
    end
    for (int i = 8'h30; i < 8'h3A; i++) if (mem[i] === 16'h7777) n++;
    total++; if (n !== 3) begin bad++; $display("FAIL mrst_words got=%0d exp=3", n); end
    total++; if (post !== 0) begin bad++; $display("FAIL mrst_after got=%0d exp=0", post); end
    total++; if (mem[8'h33] !== 16'hA5A5) begin bad++; $display("FAIL mrst_edge got=%h exp=a5a5", mem[8'h33]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    test_reset;
    test_store_load;
    test_copy_wrap;
    test_copy_overlap;
    test_zero_len;
    test_back_to_back;
    test_fill;
    test_reset_mid_fill;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
